clk_nco_gen: RTL and testbench

Parametrised multi-channel clock generator built as numerically controlled oscillators (phase accumulators) on the single board clock. It generalises the fixed-ratio PLL clock wrappers with:
- N independent channels, each with a run-time programmable frequency at a resolution of FCLK_HZ/2^ACC_W.
- Per-channel enable.
- A settle/lock indicator.

Each channel outputs a one-cycle strobe for use as a clock enable and a square wave for driving pins. The block sits next to the board clock input and feeds audio, sound and display timing logic that needs rates no PLL ratio can hit.

---
 rtl/clk_nco_gen.sv | 138 +++++++++++++
 tb/tb_clk_nco_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_nco_gen.sv
// clk_nco_gen -- multi-channel NCO clock generator on a single board clock.
//
// Each channel is a phase accumulator stepped by a run-time programmable
// increment. Output frequency is FCLK_HZ * inc / 2^ACC_W; the increment is
// clamped to 2^(ACC_W-1) so no channel can exceed FCLK_HZ/2.
//
// Parameters:
//   FCLK_HZ      board clock frequency (documentation; must be non-zero)
//   N_CH         number of channels
//   ACC_W        accumulator width
//   LOCK_CYCLES  stable cycles before locked_o rises (>= 1)
//   DEFAULT_INC  increment loaded into every channel at reset (clamped)
//
// Ports:
//   clk       board clock
//   rst_n     asynchronous active-low reset
//   inc_i     per-channel increment, channel k at inc_i[k*ACC_W +: ACC_W]
//   load_i    latch inc_i into all channels
//   en_i      per-channel run enable
//   stb_o     one-cycle pulse per accumulator wrap
//   clk_o     square wave, accumulator MSB straight from the register
//   locked_o  configuration stable for LOCK_CYCLES cycles
//
// Optional feature macro: CLK_NCO_GEN_PHASE_ALIGN_EN
//   defined   -> a load edge also zeroes every accumulator and strobe, so all
//                channels restart phase-aligned
//   undefined -> a load only changes the increment; phase is preserved

module clk_nco_gen #(
  parameter longint unsigned FCLK_HZ     = 64'd27000000,
  parameter int unsigned     N_CH        = 2,
  parameter int unsigned     ACC_W       = 32,
  parameter int unsigned     LOCK_CYCLES = 16,
  parameter longint unsigned DEFAULT_INC = 64'd159072863
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*ACC_W-1:0]  inc_i,
  input  logic                   load_i,
  input  logic [N_CH-1:0]        en_i,
  output logic [N_CH-1:0]        stb_o,
  output logic [N_CH-1:0]        clk_o,
  output logic                   locked_o
);

  localparam int unsigned        LK_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [ACC_W-1:0]   INC_MAX  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LK_W-1:0]    LOCK_MAX = LK_W'(LOCK_CYCLES);
  localparam logic [ACC_W-1:0]   RST_INC  =
    (DEFAULT_INC > 64'(INC_MAX)) ? INC_MAX : ACC_W'(DEFAULT_INC);

  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("clk_nco_gen: LOCK_CYCLES must be at least 1");
  end
  if (FCLK_HZ == 0) begin : g_bad_fclk
    $error("clk_nco_gen: FCLK_HZ must be non-zero");
  end

  function automatic logic [ACC_W-1:0] clamp_inc(input logic [ACC_W-1:0] v);
    return (v > INC_MAX) ? INC_MAX : v;
  endfunction

  logic [ACC_W-1:0] acc_q [N_CH];
  logic [ACC_W-1:0] acc_d [N_CH];
  logic [ACC_W-1:0] inc_q [N_CH];
  logic [ACC_W-1:0] inc_d [N_CH];
  logic [ACC_W:0]   sum   [N_CH];
  logic [N_CH-1:0]  stb_q, stb_d;
  logic [LK_W-1:0]  lock_q, lock_d;
  logic             locked_q, locked_d;

  // Channel datapath: accumulate with the increment currently held, so a
  // load coinciding with an enabled edge only takes effect from the next edge.
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      sum[k]   = {1'b0, acc_q[k]} + {1'b0, inc_q[k]};
      acc_d[k] = acc_q[k];
      inc_d[k] = inc_q[k];
      stb_d[k] = 1'b0;

      if (en_i[k]) begin
        acc_d[k] = sum[k][ACC_W-1:0];
        stb_d[k] = sum[k][ACC_W];
      end

      if (load_i) begin
        inc_d[k] = clamp_inc(inc_i[k*ACC_W +: ACC_W]);
`ifdef CLK_NCO_GEN_PHASE_ALIGN_EN
        acc_d[k] = '0;
        stb_d[k] = 1'b0;
`endif
      end
    end
  end

  // Lock counter saturates at LOCK_CYCLES; locked is decoded from the next
  // count so that it is registered yet aligned with the counter itself.
  always_comb begin
    lock_d   = lock_q;
    locked_d = 1'b0;
    if (load_i) begin
      lock_d = '0;
    end else if (lock_q != LOCK_MAX) begin
      lock_d = lock_q + 1'b1;
    end
    locked_d = !load_i && (lock_d == LOCK_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        acc_q[k] <= '0;
        inc_q[k] <= RST_INC;
      end
      stb_q    <= '0;
      lock_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        acc_q[k] <= acc_d[k];
        inc_q[k] <= inc_d[k];
      end
      stb_q    <= stb_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      clk_o[k] = acc_q[k][ACC_W-1];
    end
  end

  assign stb_o    = stb_q;
  assign locked_o = locked_q;

endmodule

// File: tb/tb_clk_nco_gen.sv
// tb_clk_nco_gen -- directed bench for clk_nco_gen (ACC_W=8, N_CH=2,
// LOCK_CYCLES=16). A behavioural model predicts outputs for each edge and
// queues them; they are popped and compared after the edge. Directed
// measurements (lock timing, strobe spacing, freeze, phase on load, async
// reset) are compared against constants.

module tb_clk_nco_gen;

  localparam int unsigned AW = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned LC = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC*AW-1:0] inc_i = '0;
  logic            load_i = 1'b0;
  logic [NC-1:0]   en_i = '0;
  logic [NC-1:0]   stb_o;
  logic [NC-1:0]   clk_o;
  logic            locked_o;

  clk_nco_gen #(
    .FCLK_HZ     (64'd27000000),
    .N_CH        (NC),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC),
    .DEFAULT_INC (64'd159072863)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (inc_i),
    .load_i   (load_i),
    .en_i     (en_i),
    .stb_o    (stb_o),
    .clk_o    (clk_o),
    .locked_o (locked_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0] stb;
    logic [NC-1:0] ck;
    logic          lk;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  logic [AW-1:0] m_acc [NC];
  logic [AW-1:0] m_inc [NC];
  logic [NC-1:0] m_stb;
  int            m_lock;
  logic          m_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NC; k++) begin
      m_acc[k] = '0;
      m_inc[k] = 8'd128;  // 159072863 clamped to 2^(AW-1)
    end
    m_stb    = '0;
    m_lock   = 0;
    m_locked = 1'b0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.stb = m_stb;
    for (int k = 0; k < NC; k++) e.ck[k] = m_acc[k][AW-1];
    e.lk = m_locked;
    return e;
  endfunction

  function automatic void model_edge();
    logic [AW:0] s;
    int          nv;
    for (int k = 0; k < NC; k++) begin
      if (en_i[k]) begin
        s        = {1'b0, m_acc[k]} + {1'b0, m_inc[k]};
        m_acc[k] = s[AW-1:0];
        m_stb[k] = s[AW];
      end else begin
        m_stb[k] = 1'b0;
      end
      if (load_i) begin
        nv       = int'(inc_i[k*AW +: AW]);
        m_inc[k] = (nv > 128) ? 8'd128 : AW'(nv);
`ifdef CLK_NCO_GEN_PHASE_ALIGN_EN
        m_acc[k] = '0;
        m_stb[k] = 1'b0;
`endif
      end
    end
    if (load_i) m_lock = 0;
    else if (m_lock < int'(LC)) m_lock++;
    m_locked = (m_lock == int'(LC)) && !load_i;
    sbq.push_back(model_out());
  endfunction

  task automatic check_outputs();
    exp_t e;
    checks++;
    assert (sbq.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("stb_o", 32'(stb_o), 32'(e.stb));
      chk("clk_o", 32'(clk_o), 32'(e.ck));
      chk("locked_o", 32'(locked_o), 32'(e.lk));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_inc(input logic [AW-1:0] c0, input logic [AW-1:0] c1);
    inc_i = {c1, c0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise_edge;
    int cnt;
    int hi_cnt;
    int low_cnt;
    int last;
    int ivals[$];
    int d;
    int guard;
    logic ck0;
    logic ck1;

    // Reset state
    model_reset();
    #3;
    sbq.push_back(model_out());
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Lock rises on edge 16 after release; default inc (128) on ch0
    en_i = 2'b01;
    rise_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (locked_o === 1'b1 && rise_edge == 0) rise_edge = i;
    end
    chk("lock_rise_edge", 32'(rise_edge), 32'd16);

    // inc=64 on ch0: strobe every 4 cycles, clk_o 2 high / 2 low
    set_inc(8'd64, 8'd64);
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    cnt = 0;
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (stb_o[0] === 1'b1) cnt++;
      if (clk_o[0] === 1'b1) hi_cnt++;
    end
    chk("inc64_strobes", 32'(cnt), 32'd4);
    chk("inc64_high", 32'(hi_cnt), 32'd8);

    // Clamp: 128 and 200 both run at half rate; locked low for 16 cycles
    set_inc(8'd128, 8'd200);
    en_i = 2'b11;
    load_i = 1'b1;
    tick();
    low_cnt = (locked_o === 1'b0) ? 1 : 0;
    load_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (locked_o === 1'b0) low_cnt++;
      if (stb_o[1] === 1'b1) cnt++;
    end
    chk("clamp_ch1_strobes", 32'(cnt), 32'd10);
    chk("lock_low_cycles", 32'(low_cnt), 32'd16);

    // inc=3: 3 strobes per 256 cycles, spacing 85/86; inc=0 stops ch1
    set_inc(8'd3, 8'd0);
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    ck1 = clk_o[1];
    cnt = 0;
    last = -1;
    hi_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (clk_o[1] !== ck1) hi_cnt++;
      if (stb_o[1] === 1'b1) hi_cnt++;
      if (stb_o[0] === 1'b1) begin
        if (i < 256) cnt++;
        if (last >= 0) ivals.push_back(i - last);
        last = i;
      end
    end
    chk("inc3_strobes_256", 32'(cnt), 32'd3);
    chk("inc0_activity", 32'(hi_cnt), 32'd0);
    chk("inc3_interval_count_ok", 32'(ivals.size() >= 3), 32'd1);
    if (ivals.size() >= 3) begin
      chk("inc3_three_interval_sum", 32'(ivals[0] + ivals[1] + ivals[2]), 32'd256);
      foreach (ivals[j])
        chk("inc3_interval", 32'((ivals[j] == 85) || (ivals[j] == 86)), 32'd1);
    end

    // Enable gap: ch0 frozen, no strobe, then resumes
    set_inc(8'd64, 8'd0);
    en_i = 2'b01;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    ck0 = clk_o[0];
    en_i = 2'b00;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (stb_o[0] !== 1'b0 || clk_o[0] !== ck0) cnt++;
    end
    chk("en_gap_frozen", 32'(cnt), 32'd0);
    en_i = 2'b01;
    for (int i = 0; i < 6; i++) tick();

    // Async reset mid-count with clk_o[0] high
    guard = 0;
    while (m_acc[0][AW-1] !== 1'b1 && guard < 8) begin
      tick();
      guard++;
    end
    chk("pre_reset_clk0_high", 32'(clk_o[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    sbq.push_back(model_out());
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Default increment back in force: ch0 strobes every 2 edges
    en_i = 2'b01;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (stb_o[0] === 1'b1) cnt++;
    end
    chk("post_reset_default_inc", 32'(cnt), 32'd2);

    // Bring ch0 to acc=0x50, then load inc=0x40 while enabled
    en_i = 2'b00;
    set_inc(8'h10, 8'h00);
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    en_i = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    set_inc(8'h40, 8'h00);
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    d = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (stb_o[0] === 1'b1 && d == 0) d = i;
    end
`ifdef CLK_NCO_GEN_PHASE_ALIGN_EN
    chk("first_stb_after_load", 32'(d), 32'd4);
`else
    chk("first_stb_after_load", 32'(d), 32'd3);
`endif

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
